aes_uart_axil_bridge: RTL and testbench

AES_UART_AXIL_BRIDGE -- requirements
Module: aes_uart_axil_bridge

---
 rtl/aes_uart_pkg.sv | 13 +
 rtl/aes_uart_fifo.sv | 39 +++
 rtl/aes_uart_axil_bridge.sv | 157 +++++++++++++++
 tb/tb_aes_uart_axil_bridge.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_uart_pkg.sv
// aes_uart_pkg: register indices, response codes and FSM states for the AES/UART AXI4-Lite bridge
package aes_uart_pkg;
  localparam logic [2:0] REG_TXDATA = 3'd0;
  localparam logic [2:0] REG_RXDATA = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_CTRL = 3'd3;
  localparam logic [2:0] REG_IRQ = 3'd4;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;
endpackage

// File: rtl/aes_uart_fifo.sv
// aes_uart_fifo: synchronous power-of-two FIFO with full, empty and count flags
module aes_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/aes_uart_axil_bridge.sv
// aes_uart_axil_bridge: AXI4-Lite register front-end with TX/RX byte FIFOs and interrupt for an AES/UART core
module aes_uart_axil_bridge #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic [7:0]          tx_tdata,
  output logic                tx_tvalid,
  input  logic                tx_tready,
  input  logic [7:0]          rx_tdata,
  input  logic                rx_tvalid,
  output logic                rx_tready,
  output logic                irq
);
  import aes_uart_pkg::*;
  localparam int ADDR_LSB = $clog2(DATA_W/8);
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;
  wstate_t wstate;
  rstate_t rstate;
  logic aw_held, w_held, w_strb_q, aw_ok, w_ok, do_wr, do_rd, strb;
  logic [2:0] aw_idx_q, wr_idx, rd_idx, pend, pend_set, pend_clr;
  logic [7:0] w_data_q, wd, rx_dout, rx_cnt_sat;
  logic [1:0] ctrl, wr_resp, rd_resp;
  logic [DATA_W-1:0] rd_data;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_push, tx_pop, rx_push, rx_pop;
  logic [TCW-1:0] tx_count;
  logic [RCW-1:0] rx_count;
  logic [31:0] rx_cnt_w;
  logic unused;
  assign unused = ^{s_axi_wdata[DATA_W-1:8], s_axi_wstrb[DATA_W/8-1:1],
                    s_axi_awaddr[ADDR_W-1:ADDR_LSB+3], s_axi_awaddr[ADDR_LSB-1:0],
                    s_axi_araddr[ADDR_W-1:ADDR_LSB+3], s_axi_araddr[ADDR_LSB-1:0]};
  assign s_axi_awready = wstate == W_IDLE && !aw_held;
  assign s_axi_wready = wstate == W_IDLE && !w_held;
  assign s_axi_arready = rstate == R_IDLE;
  assign aw_ok = aw_held || (s_axi_awvalid && s_axi_awready);
  assign w_ok = w_held || (s_axi_wvalid && s_axi_wready);
  assign do_wr = aw_ok && w_ok;
  assign wr_idx = aw_held ? aw_idx_q : s_axi_awaddr[ADDR_LSB+2:ADDR_LSB];
  assign wd = w_held ? w_data_q : s_axi_wdata[7:0];
  assign strb = w_held ? w_strb_q : s_axi_wstrb[0];
  assign do_rd = s_axi_arvalid && s_axi_arready;
  assign rd_idx = s_axi_araddr[ADDR_LSB+2:ADDR_LSB];
  assign tx_push = do_wr && wr_idx == REG_TXDATA && strb && !tx_full;
  assign tx_pop = !tx_empty && tx_tready;
  assign rx_push = rx_tvalid && !rx_full;
  assign rx_pop = do_rd && rd_idx == REG_RXDATA && !rx_empty;
  assign tx_tvalid = !tx_empty;
  assign rx_tready = !rx_full;
  assign wr_resp = wr_idx == REG_TXDATA ? (strb && tx_full ? RESP_SLVERR : RESP_OKAY) :
                   (wr_idx == REG_CTRL || wr_idx == REG_IRQ) ? RESP_OKAY : RESP_DECERR;
  assign rx_cnt_w = 32'(rx_count);
  assign rx_cnt_sat = rx_cnt_w > 32'd255 ? 8'hff : rx_cnt_w[7:0];
  assign pend_set = {rx_tvalid && rx_full, tx_pop && !tx_push && tx_count == TCW'(1), rx_push && rx_empty};
  assign pend_clr = do_wr && wr_idx == REG_IRQ && strb ? wd[2:0] : 3'b000;
  aes_uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx (
    .clk(Clk), .rst_n(Rst), .push(tx_push), .pop(tx_pop), .din(wd), .dout(tx_tdata),
    .full(tx_full), .empty(tx_empty), .count(tx_count)
  );
  aes_uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx (
    .clk(Clk), .rst_n(Rst), .push(rx_push), .pop(rx_pop), .din(rx_tdata), .dout(rx_dout),
    .full(rx_full), .empty(rx_empty), .count(rx_count)
  );
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_idx)
      REG_TXDATA: rd_resp = RESP_OKAY;
      REG_RXDATA: begin
        rd_data[7:0] = rx_empty ? 8'h00 : rx_dout;
        rd_resp = rx_empty ? RESP_SLVERR : RESP_OKAY;
      end
      REG_STATUS: rd_data[15:0] = {rx_cnt_sat, 4'h0, rx_empty, rx_full, tx_empty, tx_full};
      REG_CTRL: rd_data[1:0] = ctrl;
      REG_IRQ: rd_data[2:0] = pend;
      default: rd_resp = RESP_DECERR;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      wstate <= W_IDLE;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp <= RESP_OKAY;
      ctrl <= '0;
    end else if (wstate == W_IDLE) begin
      aw_held <= aw_ok && !do_wr;
      w_held <= w_ok && !do_wr;
      if (s_axi_awvalid && s_axi_awready) aw_idx_q <= s_axi_awaddr[ADDR_LSB+2:ADDR_LSB];
      if (s_axi_wvalid && s_axi_wready) begin
        w_data_q <= s_axi_wdata[7:0];
        w_strb_q <= s_axi_wstrb[0];
      end
      if (do_wr) begin
        wstate <= W_RESP;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp <= wr_resp;
      end
      if (do_wr && wr_idx == REG_CTRL && strb) ctrl <= wd[1:0];
    end else if (s_axi_bready) begin
      wstate <= W_IDLE;
      s_axi_bvalid <= 1'b0;
    end
  end
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      rstate <= R_IDLE;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
    end else if (rstate == R_IDLE) begin
      if (do_rd) begin
        rstate <= R_DATA;
        s_axi_rvalid <= 1'b1;
        s_axi_rdata <= rd_data;
        s_axi_rresp <= rd_resp;
      end
    end else if (s_axi_rready) begin
      rstate <= R_IDLE;
      s_axi_rvalid <= 1'b0;
    end
  end
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      pend <= '0;
      irq <= 1'b0;
    end else begin
      pend <= (pend & ~pend_clr) | pend_set;
      irq <= |(pend & {1'b1, ctrl});
    end
  end
endmodule

// File: tb/tb_aes_uart_axil_bridge.sv
// tb_aes_uart_axil_bridge: directed stimulus with a queue-based reference model compared every cycle
module tb_aes_uart_axil_bridge;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int TX_DEPTH = 16;
  localparam int RX_DEPTH = 16;
  localparam logic [1:0] OK = 2'b00, SLV = 2'b10, DEC = 2'b11;
  logic clk = 0;
  logic Rst;
  logic [ADDR_W-1:0] s_axi_awaddr, s_axi_araddr;
  logic s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [DATA_W-1:0] s_axi_wdata, s_axi_rdata;
  logic [DATA_W/8-1:0] s_axi_wstrb;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
  logic [7:0] tx_tdata, rx_tdata;
  logic tx_tvalid, tx_tready, rx_tvalid, rx_tready, irq;
  always #5 clk = ~clk;
  aes_uart_axil_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
    .Clk(clk), .Rst(Rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .irq(irq)
  );
  int n_tests = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  logic [7:0] tx_q[$], rx_q[$], drained[$];
  logic [1:0] m_ctrl, m_bresp, m_rresp;
  logic [2:0] m_pend, m_awi;
  logic [7:0] m_wd;
  logic [31:0] m_rdata;
  bit m_init = 0, m_irq, m_aw, m_w, m_strb, m_bpend, m_rpend;
  task automatic model_step();
    int txn, rxn;
    logic [2:0] set, clr, pp;
    logic [1:0] pc;
    if (!Rst) begin
      tx_q.delete();
      rx_q.delete();
      m_ctrl = 0; m_pend = 0; m_irq = 0; m_aw = 0; m_w = 0; m_bpend = 0; m_rpend = 0;
      m_bresp = OK; m_rresp = OK; m_rdata = 0; m_init = 1;
    end else begin
      txn = tx_q.size(); rxn = rx_q.size(); pp = m_pend; pc = m_ctrl; set = 0; clr = 0;
      m_irq = (pp[0] && pc[0]) || (pp[1] && pc[1]) || pp[2];
      if (tx_tready && txn > 0) void'(tx_q.pop_front());
      if (!m_bpend) begin
        if (s_axi_awvalid && !m_aw) begin m_aw = 1; m_awi = s_axi_awaddr[4:2]; end
        if (s_axi_wvalid && !m_w) begin m_w = 1; m_wd = s_axi_wdata[7:0]; m_strb = s_axi_wstrb[0]; end
        if (m_aw && m_w) begin
          m_aw = 0; m_w = 0; m_bpend = 1; m_bresp = OK;
          case (m_awi)
            3'd0: if (m_strb) begin if (txn == TX_DEPTH) m_bresp = SLV; else tx_q.push_back(m_wd); end
            3'd3: if (m_strb) m_ctrl = m_wd[1:0];
            3'd4: if (m_strb) clr = m_wd[2:0];
            default: m_bresp = DEC;
          endcase
        end
      end else if (s_axi_bready) m_bpend = 0;
      if (!m_rpend) begin
        if (s_axi_arvalid) begin
          m_rpend = 1; m_rdata = 0; m_rresp = OK;
          case (s_axi_araddr[4:2])
            3'd0: m_rdata = 0;
            3'd1: if (rxn == 0) m_rresp = SLV; else m_rdata = {24'h0, rx_q.pop_front()};
            3'd2: m_rdata = {16'h0, 8'(rxn > 255 ? 255 : rxn), 4'h0, rxn == 0, rxn == RX_DEPTH, txn == 0, txn == TX_DEPTH};
            3'd3: m_rdata = {30'h0, pc};
            3'd4: m_rdata = {29'h0, pp};
            default: m_rresp = DEC;
          endcase
        end
      end else if (s_axi_rready) m_rpend = 0;
      if (rx_tvalid) begin
        if (rxn == RX_DEPTH) set[2] = 1; else rx_q.push_back(rx_tdata);
      end
      if (rxn == 0 && rx_q.size() > 0) set[0] = 1;
      if (txn > 0 && tx_q.size() == 0) set[1] = 1;
      m_pend = (pp & ~clr) | set;
    end
  endtask
  always @(posedge clk) model_step();
  always @(negedge clk) begin
    if (m_init) begin
      check("tx_tvalid", tx_tvalid, tx_q.size() != 0);
      if (tx_q.size() != 0) check("tx_tdata", tx_tdata, tx_q[0]);
      check("rx_tready", rx_tready, rx_q.size() < RX_DEPTH);
      check("irq", irq, m_irq);
      check("awready", s_axi_awready, !m_bpend && !m_aw);
      check("wready", s_axi_wready, !m_bpend && !m_w);
      check("arready", s_axi_arready, !m_rpend);
      check("bvalid", s_axi_bvalid, m_bpend);
      if (m_bpend) check("bresp", s_axi_bresp, m_bresp);
      check("rvalid", s_axi_rvalid, m_rpend);
      if (m_rpend) begin
        check("rdata", s_axi_rdata, m_rdata);
        check("rresp", s_axi_rresp, m_rresp);
      end
    end
  end
  task automatic axi_write(input logic [2:0] idx, input logic [7:0] d, input logic s, input int aw_at,
                           input int w_at, input bit hold_b, output logic [1:0] resp, output int lat);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int c = 0;
    resp = 2'b01; lat = -1;
    s_axi_awaddr = 32'hABC0_0000 | (32'(idx) << 2);
    s_axi_wdata = {24'hFFFF_FF, d};
    s_axi_wstrb = {3'b111, s};
    while (!(aw_done && w_done) && c < 50) begin
      s_axi_awvalid = !aw_done && c >= aw_at;
      s_axi_wvalid = !w_done && c >= w_at;
      @(negedge clk);
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs = s_axi_wvalid && s_axi_wready;
      @(posedge clk); #1;
      aw_done |= aw_hs; w_done |= w_hs; c++;
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    if (!(aw_done && w_done)) check("wr_handshake_timeout", 0, 1);
    s_axi_bready = !hold_b;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_axi_bvalid) begin resp = s_axi_bresp; lat = c + k; break; end
      @(posedge clk); #1;
    end
    if (lat < 0) check("bvalid_timeout", 0, 1);
    if (!hold_b) begin
      @(posedge clk); #1;
      s_axi_bready = 0;
    end
  endtask
  task automatic axi_read(input logic [2:0] idx, input int hold, output logic [31:0] data, output logic [1:0] resp);
    bit got = 0;
    s_axi_araddr = 32'h5550_0000 | (32'(idx) << 2);
    s_axi_arvalid = 1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk); got = s_axi_arready;
      @(posedge clk); #1;
    end
    s_axi_arvalid = 0;
    if (!got) check("arready_timeout", 0, 1);
    data = 32'hDEAD_BEEF; resp = 2'b01;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (h == 0) begin data = s_axi_rdata; resp = s_axi_rresp; end
      else begin check("rdata_hold", s_axi_rdata, data); check("rresp_hold", s_axi_rresp, resp); end
      @(posedge clk); #1;
    end
    s_axi_rready = 1;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (s_axi_rvalid) begin got = 1; data = s_axi_rdata; resp = s_axi_rresp; end
      @(posedge clk); #1;
    end
    s_axi_rready = 0;
    if (!got) check("rvalid_timeout", 0, 1);
  endtask
  task automatic rx_inject(input logic [7:0] b);
    rx_tvalid = 1; rx_tdata = b;
    @(posedge clk); #1;
    rx_tvalid = 0;
  endtask
  task automatic drain(input int n);
    drained.delete();
    tx_tready = 1;
    for (int k = 0; k < n + 20 && drained.size() < n; k++) begin
      @(negedge clk);
      if (tx_tvalid) drained.push_back(tx_tdata);
      @(posedge clk); #1;
    end
    tx_tready = 0;
    check("drain_count", drained.size(), n);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [1:0] r;
    logic [31:0] d;
    int lat;
    Rst = 0; s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 0; s_axi_arvalid = 0; s_axi_rready = 0;
    s_axi_awaddr = 0; s_axi_araddr = 0; s_axi_wdata = 0; s_axi_wstrb = 0;
    tx_tready = 0; rx_tvalid = 0; rx_tdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_tvalid", tx_tvalid, 0);
    check("rst_rx_tready", rx_tready, 1);
    check("rst_bvalid", s_axi_bvalid, 0);
    check("rst_rvalid", s_axi_rvalid, 0);
    check("rst_irq", irq, 0);
    check("rst_rdata", s_axi_rdata, 0);
    Rst = 1;
    axi_read(3'd3, 0, d, r); check("rst_ctrl", d, 0);
    axi_read(3'd2, 0, d, r); check("rst_status", d, 32'h0000_000A);
    axi_write(3'd0, 8'h5A, 1, 0, 3, 0, r, lat);
    check("aw0_w3_resp", r, OK); check("aw0_w3_lat", lat, 4);
    check("tx_head_5a", tx_tdata, 8'h5A); check("tx_valid_5a", tx_tvalid, 1);
    axi_write(3'd0, 8'hA5, 1, 2, 0, 0, r, lat);
    check("w_first_resp", r, OK); check("w_first_lat", lat, 3);
    axi_write(3'd0, 8'h3C, 1, 0, 0, 0, r, lat);
    check("same_cycle_lat", lat, 1);
    axi_write(3'd0, 8'h99, 0, 0, 0, 0, r, lat);
    check("strb0_resp", r, OK);
    drain(3);
    check("drain_a0", drained[0], 8'h5A); check("drain_a1", drained[1], 8'hA5); check("drain_a2", drained[2], 8'h3C);
    for (int i = 0; i < TX_DEPTH; i++) begin
      axi_write(3'd0, 8'(8'h80 + i), 1, 0, 0, 0, r, lat);
      check("fill_resp", r, OK);
    end
    axi_write(3'd0, 8'hEE, 1, 0, 0, 0, r, lat); check("tx_full_slverr", r, SLV);
    axi_read(3'd2, 0, d, r); check("status_tx_full", d, 32'h0000_0009);
    drain(TX_DEPTH);
    for (int i = 0; i < TX_DEPTH; i++) check($sformatf("drain_order%0d", i), drained[i], 8'(8'h80 + i));
    rx_inject(8'h11); rx_inject(8'h22);
    axi_read(3'd1, 0, d, r); check("rx1_data", d, 32'h11); check("rx1_resp", r, OK);
    axi_read(3'd1, 0, d, r); check("rx2_data", d, 32'h22); check("rx2_resp", r, OK);
    axi_read(3'd1, 0, d, r); check("rx3_data", d, 32'h0); check("rx3_resp", r, SLV);
    axi_read(3'd2, 0, d, r); check("status_rx_empty", d, 32'h0000_000A);
    axi_read(3'd4, 0, d, r); check("irq_pending_bits", d, 32'h3);
    axi_write(3'd4, 8'h07, 1, 0, 0, 0, r, lat);
    axi_write(3'd3, 8'h01, 1, 0, 0, 0, r, lat); check("ctrl_wr_resp", r, OK);
    axi_read(3'd3, 0, d, r); check("ctrl_rd", d, 32'h1);
    check("irq_idle", irq, 0);
    rx_inject(8'h33);
    repeat (2) @(posedge clk);
    #1 check("irq_rx", irq, 1);
    axi_read(3'd1, 0, d, r); check("rx_33", d, 32'h33);
    axi_write(3'd4, 8'h01, 1, 0, 0, 0, r, lat); check("w1c_resp", r, OK);
    @(posedge clk); #1 check("irq_cleared", irq, 0);
    for (int i = 0; i <= RX_DEPTH; i++) rx_inject(8'(8'h40 + i));
    axi_read(3'd4, 0, d, r); check("irq_overflow", d, 32'h5);
    axi_read(3'd2, 0, d, r); check("status_rx_full", d, 32'h0000_1006);
    axi_read(3'd6, 0, d, r); check("unmapped_resp", r, DEC); check("unmapped_data", d, 0);
    axi_write(3'd2, 8'hFF, 1, 0, 0, 0, r, lat); check("wr_status_decerr", r, DEC);
    axi_write(3'd1, 8'hFF, 1, 0, 0, 0, r, lat); check("wr_rxdata_decerr", r, DEC);
    axi_read(3'd1, 5, d, r); check("held_rx_data", d, 32'h40); check("held_rx_resp", r, OK);
    axi_read(3'd2, 0, d, r); check("status_single_pop", d, 32'h0000_0F02);
    axi_write(3'd3, 8'h03, 1, 0, 0, 0, r, lat);
    axi_write(3'd0, 8'h77, 1, 0, 0, 1, r, lat);
    check("bvalid_before_rst", s_axi_bvalid, 1);
    @(posedge clk); #1 Rst = 0;
    @(posedge clk); #1;
    check("mid_rst_bvalid", s_axi_bvalid, 0);
    check("mid_rst_tx_tvalid", tx_tvalid, 0);
    check("mid_rst_rx_tready", rx_tready, 1);
    Rst = 1;
    axi_read(3'd3, 0, d, r); check("mid_rst_ctrl", d, 0);
    axi_read(3'd2, 0, d, r); check("mid_rst_status", d, 32'h0000_000A);
    repeat (3) @(posedge clk);
    #1 $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
